// File: rtl/sprite_overlay_anim_pkg.sv
// Shared types and helpers for the animated overlay sprite: pixel format, game states,
// overlay FSM states and the ROM address-width rule.
package sprite_overlay_anim_pkg;

    typedef logic [2:0][3:0] rgb12_t;

    typedef enum logic [1:0] {
        GS_TITLE = 2'd0,
        GS_PLAY  = 2'd1,
        GS_OVER  = 2'd2,
        GS_PAUSE = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        HIDDEN = 2'd0,
        ENTER  = 2'd1,
        SHOWN  = 2'd2,
        EXIT   = 2'd3
    } overlay_state_t;

    function automatic int rom_addr_w(input int w, input int h, input int f);
        return ((w * h * f) > 1) ? $clog2(w * h * f) : 1;
    endfunction

    // Stored words are {alpha, R[3:0], G[3:0], B[3:0]}; color[0] carries red.
    function automatic rgb12_t rgb_from_word(input logic [11:0] w);
        return {w[3:0], w[7:4], w[11:8]};
    endfunction

endpackage

// File: rtl/sprite_overlay_anim_if.sv
// Beam-position inputs and pixel outputs of the overlay layer, bundled for the mixer.
interface sprite_overlay_anim_if;
    import sprite_overlay_anim_pkg::*;

    logic [1:0]  game_state;
    logic [10:0] beam_x;
    logic [9:0]  beam_y;
    rgb12_t      color;
    logic        is_transparent;
    logic        shown;

    modport master (
        output game_state, beam_x, beam_y,
        input  color, is_transparent, shown
    );

    modport slave (
        input  game_state, beam_x, beam_y,
        output color, is_transparent, shown
    );

endinterface

// File: rtl/sprite_overlay_anim_rom.sv
// Sprite image store with a registered read; a miss or reset yields a fully transparent black word.
// The image is a procedural stand-in for the generated artwork: rgb = F80 ^ addr[11:0] ^ addr[23:12].
module sprite_rom
    import sprite_overlay_anim_pkg::*;
#(
    parameter int W      = 230,
    parameter int H      = 282,
    parameter int FRAMES = 1,
    localparam int AW    = rom_addr_w(W, H, FRAMES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    output logic [12:0]   o_word
);

    function automatic logic [12:0] image_word(input logic [AW-1:0] addr);
        logic [23:0] a;
        a = 24'(addr);
        return {(a[3:0] == 4'hF), (a[11:0] ^ a[23:12] ^ 12'hF80)};
    endfunction

    // Registered read, masked to transparent when the beam is outside the sprite.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_word <= {1'b1, 12'h000};
        end else if (i_en) begin
            o_word <= image_word(i_addr);
        end else begin
            o_word <= {1'b1, 12'h000};
        end
    end

endmodule

// File: rtl/sprite_overlay_anim.sv
// Animated overlay sprite: slides in from the bottom while the game requests it, slides out
// afterwards, and cycles animation frames; pixels come out two clocks after the beam position.
module sprite_overlay_anim
    import sprite_overlay_anim_pkg::*;
#(
    parameter int         GAME_VIEW_LEFT_BORDER_X = 0,
    parameter int         SPRITE_W                = 230,
    parameter int         SPRITE_H                = 282,
    parameter int         POS_X                   = 56,
    parameter int         POS_Y                   = 269,
    parameter int         SCREEN_H                = 600,
    parameter logic [1:0] SHOW_STATE              = GS_OVER,
    parameter int         SLIDE_STEP              = 8,
    parameter int         FRAME_COUNT             = 1,
    parameter int         FRAME_PERIOD            = 8
) (
    input logic                  clk,
    input logic                  rst,
    sprite_overlay_anim_if.slave bus
);

    localparam int LEFT_X  = GAME_VIEW_LEFT_BORDER_X + POS_X;
    localparam int RIGHT_X = LEFT_X + SPRITE_W - 1;
    localparam int FRAME_W = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;
    localparam int TICK_W  = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int ADDR_W  = rom_addr_w(SPRITE_W, SPRITE_H, FRAME_COUNT);

    overlay_state_t      r_state, w_state_next;
    logic [10:0]         r_cur_y, w_cur_y_next;
    logic [FRAME_W-1:0]  r_frame_idx, w_frame_next;
    logic [TICK_W-1:0]   r_tick_cnt, w_tick_next;
    logic                r_shown;
    logic                r_hit1;
    logic [ADDR_W-1:0]   r_addr1;
    logic                w_tick, w_show, w_hit;
    logic [10:0]         w_beam_y, w_row, w_col;
    logic [ADDR_W-1:0]   w_addr;
    logic [12:0]         w_rom_word;

    // State only moves just past the last visible row, so the sprite never tears mid-frame.
    assign w_tick = (bus.beam_x == 11'd0) && (bus.beam_y == 10'(SCREEN_H));
    assign w_show = (bus.game_state == SHOW_STATE);

    // Slide FSM and animation counters; all of it holds except on the frame tick.
    always_comb begin
        w_state_next = r_state;
        w_cur_y_next = r_cur_y;
        w_frame_next = r_frame_idx;
        w_tick_next  = r_tick_cnt;
        if (w_tick) begin
            case (r_state)
                HIDDEN: begin
                    w_frame_next = '0;
                    w_tick_next  = '0;
                    w_cur_y_next = 11'(SCREEN_H);
                    if (w_show) w_state_next = ENTER;
                    else        w_state_next = HIDDEN;
                end
                ENTER: begin
                    if (!w_show) begin
                        w_state_next = EXIT;
                    end else if (r_cur_y <= 11'(POS_Y + SLIDE_STEP)) begin
                        w_cur_y_next = 11'(POS_Y);
                        w_state_next = SHOWN;
                    end else begin
                        w_cur_y_next = r_cur_y - 11'(SLIDE_STEP);
                    end
                end
                SHOWN: begin
                    if (!w_show) w_state_next = EXIT;
                    else         w_state_next = SHOWN;
                end
                EXIT: begin
                    if (w_show) begin
                        w_state_next = ENTER;
                    end else if ((r_cur_y + 11'(SLIDE_STEP)) >= 11'(SCREEN_H)) begin
                        w_cur_y_next = 11'(SCREEN_H);
                        w_state_next = HIDDEN;
                        w_frame_next = '0;
                        w_tick_next  = '0;
                    end else begin
                        w_cur_y_next = r_cur_y + 11'(SLIDE_STEP);
                    end
                end
                default: begin
                    w_state_next = HIDDEN;
                    w_cur_y_next = 11'(SCREEN_H);
                end
            endcase
            if ((r_state == ENTER) || (r_state == SHOWN)) begin
                if (r_tick_cnt == TICK_W'(FRAME_PERIOD - 1)) begin
                    w_tick_next = '0;
                    if (r_frame_idx == FRAME_W'(FRAME_COUNT - 1)) w_frame_next = '0;
                    else                                          w_frame_next = r_frame_idx + FRAME_W'(1);
                end else begin
                    w_tick_next = r_tick_cnt + TICK_W'(1);
                end
            end else begin
                w_tick_next = w_tick_next;
            end
        end else begin
            w_state_next = r_state;
        end
    end

    // FSM, slide position, animation counters and the shown flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HIDDEN;
            r_cur_y     <= 11'(SCREEN_H);
            r_frame_idx <= '0;
            r_tick_cnt  <= '0;
            r_shown     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cur_y     <= w_cur_y_next;
            r_frame_idx <= w_frame_next;
            r_tick_cnt  <= w_tick_next;
            r_shown     <= (w_state_next == SHOWN);
        end
    end

    assign w_beam_y = {1'b0, bus.beam_y};
    assign w_row    = w_beam_y - r_cur_y;
    assign w_col    = bus.beam_x - 11'(LEFT_X);
    assign w_hit    = (r_state != HIDDEN)
                   && (bus.beam_x >= 11'(LEFT_X)) && (bus.beam_x <= 11'(RIGHT_X))
                   && (w_beam_y >= r_cur_y) && (w_beam_y < (r_cur_y + 11'(SPRITE_H)))
                   && (bus.beam_y < 10'(SCREEN_H));
    assign w_addr   = ADDR_W'((32'(r_frame_idx) * 32'(SPRITE_H) + 32'(w_row)) * 32'(SPRITE_W)
                              + 32'(w_col));

    // First pipeline stage: hit flag and ROM address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit1  <= 1'b0;
            r_addr1 <= '0;
        end else begin
            r_hit1  <= w_hit;
            r_addr1 <= w_addr;
        end
    end

    sprite_rom #(
        .W      (SPRITE_W),
        .H      (SPRITE_H),
        .FRAMES (FRAME_COUNT)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_hit1),
        .i_addr (r_addr1),
        .o_word (w_rom_word)
    );

    assign bus.color          = rgb_from_word(w_rom_word[11:0]);
    assign bus.is_transparent = w_rom_word[12];
    assign bus.shown          = r_shown;

endmodule

// File: tb/tb_sprite_overlay_anim.sv
// Directed bench: two overlays (1 frame / 3 frames) share one beam and game state; a small
// reference model of the slide FSM, frame counter and image pattern supplies expected pixels.
module tb_sprite_overlay_anim;
    import sprite_overlay_anim_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  gs;
    logic [10:0] bx;
    logic [9:0]  by;
    int checks = 0;
    int errors = 0;

    int m_state, m_y, m_frame, m_cnt;

    sprite_overlay_anim_if if0 ();
    sprite_overlay_anim_if if1 ();

    assign if0.game_state = gs;
    assign if0.beam_x     = bx;
    assign if0.beam_y     = by;
    assign if1.game_state = gs;
    assign if1.beam_x     = bx;
    assign if1.beam_y     = by;

    sprite_overlay_anim u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    sprite_overlay_anim #(.FRAME_COUNT(3), .FRAME_PERIOD(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] px0();
        return {if0.is_transparent, if0.color[0], if0.color[1], if0.color[2]};
    endfunction

    function automatic logic [12:0] px1();
        return {if1.is_transparent, if1.color[0], if1.color[1], if1.color[2]};
    endfunction

    // Expected {transparent, R, G, B} at (x, y) for a sprite showing animation frame 'frame'.
    function automatic logic [12:0] exp_px(input int x, input int y, input int frame);
        logic [31:0] a;
        if (m_state != 0 && x >= 56 && x <= 285 && y >= m_y && y < m_y + 282 && y < 600) begin
            a = 32'(frame * 64860 + (y - m_y) * 230 + (x - 56));
            return {(a[3:0] == 4'hF), (12'hF80 ^ a[11:0] ^ a[23:12])};
        end
        return 13'h1000;
    endfunction

    task automatic model_tick();
        int  ny;
        bit  show;
        bit  anim;
        show = (gs == 2'd2);
        anim = (m_state == 1 || m_state == 2);
        case (m_state)
            0: begin
                m_frame = 0; m_cnt = 0; m_y = 600;
                if (show) m_state = 1;
            end
            1: begin
                if (!show) m_state = 3;
                else begin
                    ny = m_y - 8;
                    if (ny <= 269) begin m_y = 269; m_state = 2; end
                    else m_y = ny;
                end
            end
            2: if (!show) m_state = 3;
            default: begin
                if (show) m_state = 1;
                else begin
                    ny = m_y + 8;
                    if (ny >= 600) begin m_y = 600; m_state = 0; m_frame = 0; m_cnt = 0; end
                    else m_y = ny;
                end
            end
        endcase
        if (anim) begin
            if (m_cnt == 1) begin m_cnt = 0; m_frame = (m_frame == 2) ? 0 : m_frame + 1; end
            else m_cnt = m_cnt + 1;
        end
    endtask

    task automatic do_tick();
        @(negedge clk); bx = 11'd0;    by = 10'd600;
        @(negedge clk); bx = 11'd2000; by = 10'd0;
        model_tick();
    endtask

    task automatic probe(input string tag, input int x, input int y);
        @(negedge clk); bx = 11'(x); by = 10'(y);
        @(posedge clk); @(posedge clk); #1;
        check({tag, "_d0"}, 32'(px0()), 32'(exp_px(x, y, 0)));
        check({tag, "_d1"}, 32'(px1()), 32'(exp_px(x, y, m_frame)));
        bx = 11'd2000; by = 10'd0;
    endtask

    // Hand-computed pixel on the single-frame overlay, with a one-clock latency check.
    task automatic probe_fix(input string tag, input int x, input int y, input logic [12:0] exp);
        repeat (2) @(negedge clk);
        bx = 11'(x); by = 10'(y);
        @(posedge clk); #1;
        check({tag, "_lat1"}, 32'(px0()), 32'h1000);
        @(posedge clk); #1;
        check(tag, 32'(px0()), 32'(exp));
        bx = 11'd2000; by = 10'd0;
    endtask

    task automatic step(input string tag);
        do_tick();
        check({tag, "_shown0"}, 32'(if0.shown), 32'(m_state == 2));
        check({tag, "_shown1"}, 32'(if1.shown), 32'(m_state == 2));
        if (m_state != 0) begin
            probe({tag, "_top"}, 56, m_y);
            probe({tag, "_above"}, 56, m_y - 1);
        end else begin
            probe({tag, "_hidden"}, 56, 599);
        end
    endtask

    initial begin
        rst = 1'b1; gs = 2'd0; bx = 11'd2000; by = 10'd0;
        m_state = 0; m_y = 600; m_frame = 0; m_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check("rst_px0", 32'(px0()), 32'h1000);
        check("rst_px1", 32'(px1()), 32'h1000);
        check("rst_shown", 32'(if0.shown), 32'h0);
        probe_fix("rst_nohit", 56, 300, 13'h1000);

        // Slide in: 592, 584, ... then clamp at 269
        gs = 2'd2;
        for (int k = 1; k <= 43; k++) begin
            step("enter");
            if (k == 2) begin
                probe_fix("t1_592", 56, 592, 13'h0F80);
                probe_fix("t1_591", 56, 591, 13'h1000);
                probe("t1_clip600", 56, 600);
                probe("t1_row599", 56, 599);
            end
            if (k == 42) check("t1_not_yet", 32'(if0.shown), 32'h0);
        end
        check("t1_shown", 32'(if0.shown), 32'h1);

        // Shown at rest: column edges and bottom row
        probe_fix("t2_hit", 56, 269, 13'h0F80);
        probe_fix("t2_left", 55, 269, 13'h1000);
        probe_fix("t2_right", 286, 269, 13'h1000);
        probe_fix("t1_rest_above", 56, 268, 13'h1000);
        probe("t2_lastcol", 285, 269);
        probe("t2_lastrow", 56, 550);
        probe("t2_belowsprite", 56, 551);

        // Animation frames on the three-frame overlay
        for (int k = 0; k < 7; k++) begin
            step("anim");
            probe("anim_mid", 100, 300);
        end

        // Slide out fully, then back in to 400
        gs = 2'd1;
        for (int n = 0; n < 100 && m_state != 0; n++) step("exit1");
        gs = 2'd2;
        for (int n = 0; n < 100 && !(m_state == 1 && m_y == 400); n++) step("enter2");

        // Reversal ENTER -> EXIT at 400
        gs = 2'd1;
        step("t3_rev");
        probe_fix("t3_400", 56, 400, 13'h0F80);
        probe_fix("t3_399", 56, 399, 13'h1000);
        step("t3_next");
        probe_fix("t3_408", 56, 408, 13'h0F80);
        probe_fix("t3_407", 56, 407, 13'h1000);
        for (int n = 0; n < 20 && m_y < 496; n++) step("t3_out");

        // Reversal EXIT -> ENTER at 496, no jump
        gs = 2'd2;
        step("t4_rev");
        probe_fix("t4_496", 56, 496, 13'h0F80);
        step("t4_next");
        probe_fix("t4_488", 56, 488, 13'h0F80);
        probe_fix("t4_487", 56, 487, 13'h1000);

        // Exit to hidden: everything transparent
        gs = 2'd1;
        for (int n = 0; n < 100 && m_state != 0; n++) step("exit2");
        probe_fix("t3_hid599", 56, 599, 13'h1000);
        probe_fix("t3_hid590", 100, 590, 13'h1000);
        check("t3_hid_shown", 32'(if0.shown), 32'h0);

        // Reset mid-slide with a hit in the pipeline
        gs = 2'd2;
        for (int k = 0; k < 4; k++) do_tick();
        @(negedge clk); bx = 11'd56; by = 10'(m_y);
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1; bx = 11'd2000; by = 10'd0;
        @(posedge clk); #1;
        check("t6_rst_px0", 32'(px0()), 32'h1000);
        check("t6_rst_px1", 32'(px1()), 32'h1000);
        @(negedge clk); rst = 1'b0;
        m_state = 0; m_y = 600; m_frame = 0; m_cnt = 0;
        probe_fix("t6_hidden", 56, 576, 13'h1000);
        do_tick();
        do_tick();
        probe_fix("t6_592", 56, 592, 13'h0F80);
        probe("t6_restart", 56, 592);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
